// File: rtl/memory_adaptor_pkg.sv
// memory_adaptor_pkg
// Shared definitions for the byte-serial memory adaptor and its clients
// (the load-store unit uses is_io to recognise IO addresses).
//   WIDTH_*      : data_width encodings for load/store tasks
//   state_e      : adaptor FSM state encoding
//   is_io        : true when addr[17:16] selects the IO region
//   width_bytes  : number of bus bytes for a width code
//   byte_of      : pick byte idx of a word
//   put_byte     : replace byte idx of a word
package memory_adaptor_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic [1:0] IO_BASE_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  function automatic logic is_io(input logic [31:0] addr,
                                 input logic [1:0]  base = IO_BASE_DEFAULT);
    return addr[17:16] == base;
  endfunction

  // The illegal code 2'b11 is treated as a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_adaptor.sv
// memory_adaptor
// Arbitrates the 8-bit RAM/IO bus between instruction fetches (always one
// 4-byte read) and load/store tasks from the load-store unit. Each task is
// split into single-byte bus accesses; read bytes are reassembled and the
// task completes with a registered one-cycle done pulse.
//
// Handshake: request_ins_from_memory_adaptor / data_request are one-cycle
// pulses whose payload is valid in that same cycle and is latched into a
// pending slot unconditionally (the adaptor never back-pressures). A client
// issues at most one outstanding request and waits for its done pulse, which
// carries the result in the same cycle. Data tasks win over fetches.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global pause when low (state held, mem_wr = 0)
//   flush_pipline             abort active/pending instruction fetch
//   mem_din/mem_dout/mem_a/mem_wr  byte bus (read data one cycle after address)
//   io_buffer_full            IO write sink busy; stalls IO stores
//   request_ins_.../insaddr_...    fetch request and address
//   ins_fetched_.../insfetch_task_done  fetched word and done pulse
//   data_*                    load/store request, result and done pulse
//   state_dbg_o               current FSM state
module memory_adaptor
  import memory_adaptor_pkg::*;
#(
  parameter logic [1:0] IO_BASE_BITS = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        request_ins_from_memory_adaptor,
  input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
  output logic [31:0] ins_fetched_from_memory_adaptor,
  output logic        insfetch_task_done,
  input  logic        data_request,
  input  logic        data_is_write,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_width,
  input  logic        data_sign_ext,
  input  logic [31:0] data_wdata,
  output logic        data_task_done,
  output logic [31:0] data_rdata,
  output logic [1:0]  state_dbg_o
);

  // Active task
  state_e      state_q, state_d;
  logic        is_ins_q, is_ins_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  width_q, width_d;
  logic        sext_q, sext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [2:0]  i_q, i_d;          // bytes issued
  logic [2:0]  j_q, j_d;          // bytes captured (read) / written (write)
  logic        vis_q, vis_d;      // mem_a currently shows a read address
  logic        cap_q, cap_d;      // mem_din currently holds byte j
  logic [31:0] rbuf_q, rbuf_d;
  logic        rdy_q, rdy_d;      // rdy_in last cycle; low->high marks a resume

  // Pending slots
  logic        ins_pend_q, ins_pend_d;
  logic [31:0] ins_addr_q, ins_addr_d;
  logic        dat_pend_q, dat_pend_d;
  logic        dat_we_q, dat_we_d;
  logic [31:0] dat_addr_q, dat_addr_d;
  logic [1:0]  dat_width_q, dat_width_d;
  logic        dat_sext_q, dat_sext_d;
  logic [31:0] dat_wdata_q, dat_wdata_d;

  // Registered outputs
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] ins_word_q, ins_word_d;
  logic        ins_done_q, ins_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_done_q, data_done_d;

  // A request arriving in the IDLE cycle is served at once, so selection
  // looks at the incoming pulse as well as the latched slot.
  logic        dat_go, ins_go, d_we, d_sext;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic [1:0]  d_width;
  logic        io_block, last_cap;
  logic [31:0] asm_word;

  assign dat_go  = dat_pend_q | data_request;
  assign d_we    = data_request ? data_is_write : dat_we_q;
  assign d_addr  = data_request ? data_addr     : dat_addr_q;
  assign d_width = data_request ? data_width    : dat_width_q;
  assign d_sext  = data_request ? data_sign_ext : dat_sext_q;
  assign d_wdata = data_request ? data_wdata    : dat_wdata_q;
  assign ins_go  = (ins_pend_q | request_ins_from_memory_adaptor) & ~flush_pipline;
  assign i_addr  = request_ins_from_memory_adaptor ? insaddr_to_be_fetched_from_memory_adaptor
                                                   : ins_addr_q;

  assign io_block = is_io(addr_q, IO_BASE_BITS) & io_buffer_full;
  assign last_cap = (j_q + 3'd1) == nbytes_q;
  assign asm_word = put_byte(rbuf_q, j_q[1:0], mem_din);

  // Start-of-task controls produced in IDLE
  logic        st_go, st_ins, st_write, st_sext;
  logic [31:0] st_addr, st_wdata;
  logic [1:0]  st_width;

  always_comb begin
    state_d     = state_q;
    is_ins_d    = is_ins_q;
    addr_d      = addr_q;
    width_d     = width_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    nbytes_d    = nbytes_q;
    i_d         = i_q;
    j_d         = j_q;
    vis_d       = vis_q;
    cap_d       = cap_q;
    rbuf_d      = rbuf_q;
    ins_pend_d  = ins_pend_q;
    ins_addr_d  = ins_addr_q;
    dat_pend_d  = dat_pend_q;
    dat_we_d    = dat_we_q;
    dat_addr_d  = dat_addr_q;
    dat_width_d = dat_width_q;
    dat_sext_d  = dat_sext_q;
    dat_wdata_d = dat_wdata_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    ins_word_d  = ins_word_q;
    rdata_d     = rdata_q;
    ins_done_d  = 1'b0;
    data_done_d = 1'b0;
    rdy_d       = rdy_in;
    st_go       = 1'b0;
    st_ins      = 1'b0;
    st_write    = 1'b0;
    st_addr     = 32'd0;
    st_width    = WIDTH_WORD;
    st_sext     = 1'b0;
    st_wdata    = 32'd0;

    // While paused everything holds, flush included; done pulses still drop.
    if (rdy_in) begin
      if (data_request) begin
        dat_pend_d  = 1'b1;
        dat_we_d    = data_is_write;
        dat_addr_d  = data_addr;
        dat_width_d = data_width;
        dat_sext_d  = data_sign_ext;
        dat_wdata_d = data_wdata;
      end
      if (request_ins_from_memory_adaptor) begin
        ins_pend_d = 1'b1;
        ins_addr_d = insaddr_to_be_fetched_from_memory_adaptor;
      end
      if (flush_pipline) ins_pend_d = 1'b0;

      case (state_q)
        IDLE: begin
          if (dat_go) begin
            dat_pend_d = 1'b0;
            st_go      = 1'b1;
            st_write   = d_we;
            st_addr    = d_addr;
            st_width   = d_width;
            st_sext    = d_sext;
            st_wdata   = d_wdata;
          end else if (ins_go) begin
            ins_pend_d = 1'b0;
            st_go      = 1'b1;
            st_ins     = 1'b1;
            st_addr    = i_addr;
          end
        end

        READ: begin
          if (is_ins_q && flush_pipline) begin
            state_d  = IDLE;
            mem_a_d  = 32'd0;
            mem_wr_d = 1'b0;
            vis_d    = 1'b0;
            cap_d    = 1'b0;
          end else if (!rdy_q) begin
            // First cycle after a pause: mem_din cannot be trusted, so
            // re-issue from the first uncaptured byte.
            i_d     = j_q + 3'd1;
            mem_a_d = addr_q + {29'd0, j_q};
            vis_d   = 1'b1;
            cap_d   = 1'b0;
          end else if (cap_q && last_cap) begin
            state_d = IDLE;
            vis_d   = 1'b0;
            cap_d   = 1'b0;
            mem_a_d = 32'd0;
            j_d     = j_q + 3'd1;
            if (is_ins_q) begin
              ins_word_d = asm_word;
              ins_done_d = 1'b1;
            end else begin
              data_done_d = 1'b1;
              case (width_q)
                WIDTH_BYTE: rdata_d = {{24{sext_q & asm_word[7]}}, asm_word[7:0]};
                WIDTH_HALF: rdata_d = {{16{sext_q & asm_word[15]}}, asm_word[15:0]};
                default:    rdata_d = asm_word;
              endcase
            end
          end else begin
            if (cap_q) begin
              rbuf_d = asm_word;
              j_d    = j_q + 3'd1;
            end
            cap_d = vis_q;
            if (i_q < nbytes_q) begin
              mem_a_d = addr_q + {29'd0, i_q};
              i_d     = i_q + 3'd1;
              vis_d   = 1'b1;
            end else begin
              vis_d = 1'b0;
            end
          end
        end

        WRITE: begin
          // At most one byte is ever in flight, so j trails i by one and a
          // held byte after a pause is simply written once on resume.
          if (mem_wr_q && !io_block) begin
            j_d = j_q + 3'd1;
            if (last_cap) begin
              state_d     = IDLE;
              mem_wr_d    = 1'b0;
              mem_a_d     = 32'd0;
              data_done_d = 1'b1;
            end else begin
              mem_a_d    = addr_q + {29'd0, i_q};
              mem_dout_d = byte_of(wdata_q, i_q[1:0]);
              mem_wr_d   = 1'b1;
              i_d        = i_q + 3'd1;
            end
          end
        end

        default: state_d = IDLE;
      endcase

      if (st_go) begin
        state_d  = st_write ? WRITE : READ;
        is_ins_d = st_ins;
        addr_d   = st_addr;
        width_d  = st_width;
        sext_d   = st_sext;
        wdata_d  = st_wdata;
        nbytes_d = width_bytes(st_width);
        i_d      = 3'd1;
        j_d      = 3'd0;
        cap_d    = 1'b0;
        vis_d    = ~st_write;
        rbuf_d   = 32'd0;
        mem_a_d  = st_addr;
        mem_wr_d = st_write;
        if (st_write) mem_dout_d = st_wdata[7:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      is_ins_q    <= 1'b0;
      addr_q      <= 32'd0;
      width_q     <= WIDTH_WORD;
      sext_q      <= 1'b0;
      wdata_q     <= 32'd0;
      nbytes_q    <= 3'd0;
      i_q         <= 3'd0;
      j_q         <= 3'd0;
      vis_q       <= 1'b0;
      cap_q       <= 1'b0;
      rbuf_q      <= 32'd0;
      rdy_q       <= 1'b1;
      ins_pend_q  <= 1'b0;
      ins_addr_q  <= 32'd0;
      dat_pend_q  <= 1'b0;
      dat_we_q    <= 1'b0;
      dat_addr_q  <= 32'd0;
      dat_width_q <= WIDTH_WORD;
      dat_sext_q  <= 1'b0;
      dat_wdata_q <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      ins_word_q  <= 32'd0;
      ins_done_q  <= 1'b0;
      rdata_q     <= 32'd0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_ins_q    <= is_ins_d;
      addr_q      <= addr_d;
      width_q     <= width_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      nbytes_q    <= nbytes_d;
      i_q         <= i_d;
      j_q         <= j_d;
      vis_q       <= vis_d;
      cap_q       <= cap_d;
      rbuf_q      <= rbuf_d;
      rdy_q       <= rdy_d;
      ins_pend_q  <= ins_pend_d;
      ins_addr_q  <= ins_addr_d;
      dat_pend_q  <= dat_pend_d;
      dat_we_q    <= dat_we_d;
      dat_addr_q  <= dat_addr_d;
      dat_width_q <= dat_width_d;
      dat_sext_q  <= dat_sext_d;
      dat_wdata_q <= dat_wdata_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ins_word_q  <= ins_word_d;
      ins_done_q  <= ins_done_d;
      rdata_q     <= rdata_d;
      data_done_q <= data_done_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy_in & ~io_block;

  assign ins_fetched_from_memory_adaptor = ins_word_q;
  assign insfetch_task_done              = ins_done_q;
  assign data_rdata                      = rdata_q;
  assign data_task_done                  = data_done_q;
  assign state_dbg_o                     = state_q;

endmodule

// File: doc/memory_adaptor.md
# memory_adaptor

Byte-serial memory arbiter between the core and the 8-bit RAM/IO bus. It serves instruction-word fetches for the instruction cache inside the issue stage, and load/store tasks from the load-store unit. It splits each request into sequential single-byte bus accesses, reassembles read data, and signals completion with a one-cycle done pulse. Data tasks have priority over instruction fetches; instruction fetches can be aborted by a pipeline flush.

## Interface
Parameters:
- IO_BASE_BITS, default 2'b11: value of addr[17:16] that marks an IO address.

Ports:
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  pause when low.
- flush_pipline  in  1  abort any instruction fetch.
- mem_din  in  8  read byte; valid one cycle after its address is driven on mem_a.
- mem_dout  out  8  write byte.
- mem_a  out  32  bus byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  IO write sink cannot accept a byte.
- request_ins_from_memory_adaptor  in  1  one-cycle pulse requesting an instruction fetch.
- insaddr_to_be_fetched_from_memory_adaptor  in  32  fetch address; sampled with the request pulse.
- ins_fetched_from_memory_adaptor  out  32  fetched word, little-endian.
- insfetch_task_done  out  1  one-cycle pulse; data valid in the same cycle.
- data_request  in  1  one-cycle pulse requesting a data task.
- data_is_write  in  1  1 = store, 0 = load.
- data_addr  in  32  byte address; alignment not required.
- data_width  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- data_sign_ext  in  1  sign-extend sub-word loads.
- data_wdata  in  32  store data, low bytes first.
- data_task_done  out  1  one-cycle pulse.
- data_rdata  out  32  load result; valid with data_task_done.

## Operation
- States: IDLE, READ, WRITE.
- Both request pulses are latched into pending slots (address, width, write data) on the cycle they appear.
- Task selection in IDLE: data pending beats instruction pending.
  - An instruction fetch is a READ of 4 bytes.
- READ: issue counter i walks bytes 0..n-1, with mem_a = addr+i and mem_wr = 0.
  - Receive counter j captures mem_din into byte j on the cycle after byte j was issued.
  - After the last capture, the done pulse is raised and the state returns to IDLE.
- WRITE: each cycle drive mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - If addr[17:16] == IO_BASE_BITS and io_buffer_full = 1, hold i and drive mem_wr = 0.
  - After the last byte, pulse data_task_done and return to IDLE.
- Load result:
  - byte: bits 7:0, extended per data_sign_ext.
  - half: bits 15:0, extended per data_sign_ext.
  - word: passed through unchanged.
- flush_pipline:
  - If the active task is an instruction fetch, abort it: IDLE next cycle, mem_a = 0, mem_wr = 0, no done pulse.
  - The pending instruction slot is cleared, including a request arriving in the flush cycle.
  - Data tasks, active or pending, are unaffected.
- rdy_in low: all state is held and mem_wr is forced to 0.
  - On the first cycle back, i rewinds to j, so any byte issued but not captured is re-issued.
  - No byte is written twice.
- Reset values: state IDLE, pending slots clear, mem_a = 0, mem_dout = 0, mem_wr = 0, both done pulses 0, ins_fetched_from_memory_adaptor = 0, data_rdata = 0.

## Timing
- Request pulse in cycle 0 → first address on mem_a in cycle 1.
- Word read: addresses in cycles 1–4, bytes on mem_din in cycles 2–5, done in cycle 6.
- Byte read: done in cycle 3. Half read: done in cycle 4.
- Word write: mem_wr = 1 in cycles 1–4, done in cycle 5.
- Back-to-back: a new task may begin driving mem_a in the cycle after the done pulse.
- Done outputs are registered; each is high for exactly one cycle per completed task.

## Structure
- Shared package holds:
  - width encodings: WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD
  - state encoding
  - an is_io(addr) function, also used by the load-store unit
- Single module; no sub-module. Byte assembly and sign extension are small enough to stay inline.

## Test plan
- Instruction fetch at 0x1000, RAM bytes 13 05 00 00 → mem_a = 0x1000–0x1003 in cycles 1–4; insfetch_task_done in cycle 6 with word 0x00000513.
- Byte load at 0x2003 (byte 0x80) with sign_ext = 1 → data_rdata = 0xFFFFFF80 in cycle 3. Same load with sign_ext = 0 → 0x00000080.
- Data and instruction requests in the same cycle → data word write to 0x3000 runs first (done in cycle 5); the fetch starts in cycle 6 and finishes in cycle 11.
- Flush in cycle 3 of a fetch → mem_a = 0 and mem_wr = 0 in cycle 4; no insfetch_task_done ever issued for that fetch.
- Byte store of 0x41 to 0x30000 with io_buffer_full high for cycles 1–3 → mem_wr first high in cycle 4; data_task_done in cycle 5.
- rdy_in low in cycles 3–5 during a word read → the byte issued in cycle 3 is re-issued; the assembled word matches RAM contents; one done pulse.
